// File: rtl/regfile_mp_if.sv
// Issue/writeback bus of the multi-port register file. The issue/writeback
// side uses the master modport and the register file uses the slave modport.
interface regfile_mp_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic                 we_i;
  logic [AW-1:0]        waddr_i;
  logic [XLEN-1:0]      wdata_i;
  logic                 rsv_i;
  logic [AW-1:0]        rsv_addr_i;
  logic [NRD-1:0]       re_i;
  logic [NRD*AW-1:0]    raddr_i;
  logic [NRD*XLEN-1:0]  rdata_o;
  logic [NRD-1:0]       rbusy_o;

  modport master (
    output we_i, waddr_i, wdata_i, rsv_i, rsv_addr_i, re_i, raddr_i,
    input  rdata_o, rbusy_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, rsv_i, rsv_addr_i, re_i, raddr_i,
    output rdata_o, rbusy_o
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with a pending-write scoreboard.
// Index 0 is hardwired zero and never busy.
module regfile_mp #(
  parameter int              XLEN    = 64,
  parameter int              NREG    = 32,
  parameter int              AW      = 5,
  parameter int              NRD     = 2,
  parameter int              BYPASS  = 1,
  parameter logic [XLEN-1:0] RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_mp_if.slave          rf,
  output logic [NREG-1:0]      busy_o,
  output logic [NREG*XLEN-1:0] diff_reg_o
);

  if (AW != $clog2(NREG)) begin : g_bad_aw
    $error("regfile_mp: AW must equal log2(NREG)");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be in 1..4");
  end

  logic [XLEN-1:0] regs [1:NREG-1];
  logic [NREG-1:1] busy;

  // NOTE: every register is reset because RST_VAL must be architecturally
  // visible after reset; this forces flops rather than an SRAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) regs[i] <= RST_VAL;
      busy <= '0;
    end else begin
      // NOTE: non-blocking assignments; the reserve is placed after the write
      // so that, for the same index, its busy update is the one that lands.
      if (rf.we_i && rf.waddr_i != '0) begin
        regs[rf.waddr_i] <= rf.wdata_i;
        busy[rf.waddr_i] <= 1'b0;
      end
      if (rf.rsv_i && rf.rsv_addr_i != '0) begin
        busy[rf.rsv_addr_i] <= 1'b1;
      end
    end
  end

  assign busy_o = {busy, 1'b0};

  always_comb begin
    diff_reg_o = '0;
    for (int i = 1; i < NREG; i++) diff_reg_o[i*XLEN +: XLEN] = regs[i];
  end

  // Read ports look only at the write port for forwarding; reserve never
  // reaches an output combinationally.
  always_comb begin
    logic [AW-1:0] ra;
    // NOTE: defaults first so every path assigns every output bit (no latches).
    rf.rdata_o = '0;
    rf.rbusy_o = '0;
    ra         = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rf.raddr_i[k*AW +: AW];
      if (!rf.re_i[k] || ra == '0) begin
        rf.rdata_o[k*XLEN +: XLEN] = '0;
        rf.rbusy_o[k]              = 1'b0;
      end else if (BYPASS != 0 && rf.we_i && rf.waddr_i == ra) begin
        rf.rdata_o[k*XLEN +: XLEN] = rf.wdata_i;
        rf.rbusy_o[k]              = 1'b0;
      end else begin
        rf.rdata_o[k*XLEN +: XLEN] = diff_reg_o[int'(ra)*XLEN +: XLEN];
        rf.rbusy_o[k]              = busy_o[ra];
      end
    end
  end

endmodule
